load_store_unit: RTL

- Sits between the execute/ALU address path and the register file write port.
- Executes RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) against a data memory that uses a req/ack handshake.
- Handles byte-lane alignment, sign and zero extension, and misalignment detection.
- Presents loaded data to the register file as a one-cycle write-back (wb_en, wb_rd, wb_data). The core stalls on busy.

---
 rtl/load_store_unit_pkg.sv | 36 +++
 rtl/load_store_unit_if.sv | 22 ++
 rtl/load_store_unit_align.sv | 50 +++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: RV32I width codes, FSM states
// and a helper that maps a width code onto an access size.
package load_store_unit_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned REGW_DEF = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2,
        ST_ERR  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } access_size_e;

    // Low two funct3 bits carry the size; unlisted codes (011, 110, 111) fall to word.
    function automatic access_size_e f3_size(input logic [1:0] code);
        case (code)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data memory req/ack bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_wstrb;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store strobes/replicated data, load extraction with
// sign/zero extension, and misalignment detection.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_data,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_fmt,
    output logic            misaligned
);
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic        is_unsigned;

    assign lane_byte   = load_data[{offset, 3'b000} +: 8];
    assign lane_half   = load_data[{offset[1], 4'b0000} +: 16];
    assign is_unsigned = funct3[2];

    // Size-dependent lane selection for both directions.
    always_comb begin
        wstrb      = 4'b1111;
        wdata      = store_data;
        load_fmt   = load_data;
        misaligned = 1'b0;
        case (f3_size(funct3[1:0]))
            SZ_B: begin
                wstrb    = 4'b0001 << offset;
                wdata    = {(XLEN/8){store_data[7:0]}};
                load_fmt = is_unsigned ? {{(XLEN-8){1'b0}}, lane_byte}
                                       : {{(XLEN-8){lane_byte[7]}}, lane_byte};
            end
            SZ_H: begin
                wstrb      = offset[1] ? 4'b1100 : 4'b0011;
                wdata      = {(XLEN/16){store_data[15:0]}};
                load_fmt   = is_unsigned ? {{(XLEN-16){1'b0}}, lane_half}
                                         : {{(XLEN-16){lane_half[15]}}, lane_half};
                misaligned = offset[0];
            end
            default: begin
                misaligned = |offset;
            end
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: req/ack data memory master with one-cycle
// register-file write-back. All outputs registered except busy.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned REGW = REGW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   store_data,
    input  logic [REGW-1:0]   rd_in,
    output logic              busy,
    output logic              done,
    output logic              misalign_err,
    load_store_unit_if.master mem,
    output logic              wb_en,
    output logic [REGW-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_data
);
    lsu_state_e      state, state_n;
    logic            is_store_q, is_store_n;
    logic [2:0]      funct3_q, funct3_n;
    logic [1:0]      off_q, off_n;
    logic [REGW-1:0] rd_q, rd_n;

    logic            req_q, req_n, we_q, we_n;
    logic [XLEN-1:0] maddr_q, maddr_n, mwdata_q, mwdata_n;
    logic [3:0]      strb_q, strb_n;
    logic            wb_en_n, done_n, mis_n;
    logic [REGW-1:0] wb_rd_n;
    logic [XLEN-1:0] wb_data_n;

    logic [2:0]      al_f3;
    logic [1:0]      al_off;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_wdata, al_load;
    logic            al_mis;

    // The single aligner sees the live request in IDLE and the latched one afterwards.
    assign al_f3  = (state == ST_IDLE) ? funct3    : funct3_q;
    assign al_off = (state == ST_IDLE) ? addr[1:0] : off_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (al_f3),
        .offset     (al_off),
        .store_data (store_data),
        .load_data  (mem.mem_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_fmt   (al_load),
        .misaligned (al_mis)
    );

    assign busy          = (state != ST_IDLE);
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wstrb = strb_q;
    assign mem.mem_wdata = mwdata_q;

    // Next state plus next values of every registered output.
    always_comb begin
        state_n    = state;
        is_store_n = is_store_q;
        funct3_n   = funct3_q;
        off_n      = off_q;
        rd_n       = rd_q;
        req_n      = req_q;
        we_n       = we_q;
        maddr_n    = maddr_q;
        strb_n     = strb_q;
        mwdata_n   = mwdata_q;
        wb_en_n    = 1'b0;
        wb_rd_n    = wb_rd;
        wb_data_n  = wb_data;
        done_n     = 1'b0;
        mis_n      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    is_store_n = is_store;
                    funct3_n   = funct3;
                    off_n      = addr[1:0];
                    rd_n       = rd_in;
                    if (al_mis) begin
                        state_n = ST_ERR;
                        done_n  = 1'b1;
                        mis_n   = 1'b1;
                    end else begin
                        state_n  = ST_REQ;
                        req_n    = 1'b1;
                        we_n     = is_store;
                        maddr_n  = {addr[XLEN-1:2], 2'b00};
                        strb_n   = is_store ? al_wstrb : '0;
                        mwdata_n = is_store ? al_wdata : '0;
                    end
                end
            end
            ST_REQ: begin
                if (mem.mem_ack) begin
                    req_n  = 1'b0;
                    done_n = 1'b1;
                    if (is_store_q) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n   = ST_WB;
                        wb_en_n   = (rd_q != '0);
                        wb_rd_n   = rd_q;
                        wb_data_n = al_load;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            maddr_q      <= '0;
            strb_q       <= '0;
            mwdata_q     <= '0;
            wb_en        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            done         <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_n;
            is_store_q   <= is_store_n;
            funct3_q     <= funct3_n;
            off_q        <= off_n;
            rd_q         <= rd_n;
            req_q        <= req_n;
            we_q         <= we_n;
            maddr_q      <= maddr_n;
            strb_q       <= strb_n;
            mwdata_q     <= mwdata_n;
            wb_en        <= wb_en_n;
            wb_rd        <= wb_rd_n;
            wb_data      <= wb_data_n;
            done         <= done_n;
            misalign_err <= mis_n;
        end
    end
endmodule
